// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-RAM geometry, KSA state encoding and key-byte selection.
package rc4_pkg;

  localparam int KEY_BYTES = 3;
  localparam int S_DEPTH   = 256;
  localparam int S_AW      = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_I,
    S_WT_I,
    S_CP_I,
    S_CALC_J,
    S_RD_J,
    S_WT_J,
    S_CP_J,
    S_WR_J,
    S_WR_I,
    S_NEXT,
    S_DONE
  } ksa_state_t;

  // Byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                          input logic [1:0] sel);
    case (sel)
      2'd0:    return key[23:16];
      2'd1:    return key[15:8];
      default: return key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling: 256 read/read/write/write swap iterations over a
// single-port synchronous S RAM, ten cycles per iteration.
module ksa_shuffle
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic                   start,
  output logic                   finish,
  output logic [S_AW-1:0]        address_s,
  output logic [7:0]             data_s,
  output logic                   wren_s,
  input  logic [7:0]             q_s
);

  localparam logic [1:0] K_LAST = 2'(KEY_BYTES - 1);

  ksa_state_t      state_q, state_d;
  logic [S_AW-1:0] i_q, i_d;
  logic [S_AW-1:0] j_q, j_d;
  logic [7:0]      si_q, si_d;
  logic [7:0]      sj_q, sj_d;
  logic [1:0]      k_q, k_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_I;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_RD_I:   state_d = S_WT_I;
      S_WT_I:   state_d = S_CP_I;
      S_CP_I: begin
        si_d    = q_s;
        state_d = S_CALC_J;
      end
      S_CALC_J: begin
        j_d     = j_q + si_q + key_byte(secret_key, k_q);
        state_d = S_RD_J;
      end
      S_RD_J:   state_d = S_WT_J;
      S_WT_J:   state_d = S_CP_J;
      S_CP_J: begin
        sj_d    = q_s;
        state_d = S_WR_J;
      end
      S_WR_J:   state_d = S_WR_I;
      S_WR_I:   state_d = S_NEXT;
      S_NEXT: begin
        if (i_q == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == K_LAST) ? 2'd0 : k_q + 2'd1;
          state_d = S_RD_I;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Address is held through the wait/capture cycles so the RAM output stays valid.
  always_comb begin
    address_s = '0;
    data_s    = '0;
    wren_s    = 1'b0;
    finish    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: address_s = '0;
      S_RD_J, S_WT_J, S_CP_J: address_s = j_q;
      S_WR_J: begin
        address_s = j_q;
        data_s    = si_q;
        wren_s    = 1'b1;
      end
      S_WR_I: begin
        address_s = i_q;
        data_s    = sj_q;
        wren_s    = 1'b1;
      end
      default: address_s = i_q;
    endcase
    if (state_q == S_DONE) finish = 1'b1;
  end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Bench for ksa_shuffle: behavioural S RAM, golden KSA model, table-driven and random keys.
module tb_ksa_shuffle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] secret_key = '0;
  logic        start = 1'b0;
  logic        finish;
  logic [7:0]  address_s;
  logic [7:0]  data_s;
  logic        wren_s;
  logic [7:0]  q_s;

  ksa_shuffle #(.KEY_BYTES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .secret_key (secret_key),
    .start      (start),
    .finish     (finish),
    .address_s  (address_s),
    .data_s     (data_s),
    .wren_s     (wren_s),
    .q_s        (q_s)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       init_req = 1'b0;
  always @(posedge clk) begin
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren_s) begin
      mem[address_s] <= data_s;
    end
    q_s <= mem[address_s];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int        fq[$];
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  always @(posedge clk) begin
    #1;
    if (wren_s) begin
      wa.push_back(address_s);
      wd.push_back(data_s);
    end
    if (finish) fq.push_back(cyc);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int gs[256];
  int gj[256];
  task automatic golden(input logic [23:0] key);
    int kb[3];
    int j;
    int t;
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    for (int i = 0; i < 256; i++) gs[i] = i;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + gs[i] + kb[i % 3]) % 256;
      gj[i] = j;
      t = gs[i]; gs[i] = gs[j]; gs[j] = t;
    end
  endtask

  task automatic ram_init();
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
  endtask

  task automatic do_run(input logic [23:0] key, output int lat, output bit ok);
    int st;
    wa.delete(); wd.delete(); fq.delete();
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    st = cyc + 1;
    @(negedge clk) start = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      if (fq.size() > 0) ok = 1'b1;
    end
    lat = ok ? fq[0] - st : -1;
  endtask

  task automatic check_run(input string nm, input logic [23:0] key);
    int lat;
    bit ok;
    int bad;
    golden(key);
    ram_init();
    do_run(key, lat, ok);
    chk({nm, "_finish_seen"}, ok, 1);
    if (ok) begin
      chk({nm, "_latency"}, lat, 2560);
      @(negedge clk);
      chk({nm, "_finish_width"}, finish, 0);
      chk({nm, "_finish_count"}, fq.size(), 1);
      chk({nm, "_write_count"}, wa.size(), 512);
      bad = 0;
      if (wa.size() == 512) begin
        for (int p = 0; p < 256; p++) begin
          if (wa[2*p] != 8'(gj[p]) || wa[2*p+1] != 8'(p)) bad++;
        end
      end else bad = -1;
      chk({nm, "_write_pairs"}, bad, 0);
      bad = 0;
      for (int k = 0; k < 256; k++) if (mem[k] != 8'(gs[k])) bad++;
      chk({nm, "_final_S"}, bad, 0);
    end
  endtask

  typedef struct {
    logic [23:0] key;
    logic [7:0]  j0;
    logic [7:0]  j1;
    logic [7:0]  j2;
  } vec_t;

  initial begin
    vec_t tbl[2];
    int lat;
    bit ok;
    int bad;
    int st;
    tbl[0] = '{key: 24'h000000, j0: 8'd0, j1: 8'd1, j2: 8'd3};
    tbl[1] = '{key: 24'h00033C, j0: 8'd0, j1: 8'd4, j2: 8'd66};

    #1;
    chk("reset_finish", finish, 0);
    chk("reset_wren", wren_s, 0);
    chk("reset_address", address_s, 0);
    chk("reset_data", data_s, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_wren", wren_s, 0);

    for (int v = 0; v < 2; v++) begin
      check_run($sformatf("tbl%0d", v), tbl[v].key);
      if (wa.size() >= 6) begin
        chk($sformatf("tbl%0d_j0", v), wa[0], tbl[v].j0);
        chk($sformatf("tbl%0d_j1", v), wa[2], tbl[v].j1);
        chk($sformatf("tbl%0d_j2", v), wa[4], tbl[v].j2);
      end else begin
        chk($sformatf("tbl%0d_writes_present", v), wa.size(), 512);
      end
      if (v == 0 && wa.size() >= 6) begin
        chk("zero_it0_data", {wd[0], wd[1]}, 16'h0000);
        chk("selfswap_addr", {wa[2], wa[3]}, 16'h0101);
        chk("selfswap_data", {wd[2], wd[3]}, 16'h0101);
        chk("it2_data", {wd[4], wd[5], wa[5]}, 24'h020302);
      end
    end

    for (int r = 0; r < 2; r++) begin
      check_run($sformatf("rand%0d", r), 24'($urandom));
    end

    // Reset in the middle of a run
    ram_init();
    wa.delete(); fq.delete();
    @(negedge clk);
    secret_key = 24'h5A17C3;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (1000) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset_wren", wren_s, 0);
    chk("midreset_finish", finish, 0);
    chk("midreset_address", address_s, 0);
    @(negedge clk) reset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (wren_s || finish || address_s != 8'd0) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    check_run("rerun", 24'h5A17C3);

    // start held high across two complete runs
    ram_init();
    wa.delete(); fq.delete();
    @(negedge clk);
    secret_key = 24'h00033C;
    start = 1'b1;
    st = cyc + 1;
    repeat (6000) @(negedge clk);
    start = 1'b0;
    chk("held_finish_count", fq.size(), 2);
    if (fq.size() >= 2) begin
      chk("held_first_latency", fq[0] - st, 2560);
      chk("held_gap", fq[1] - fq[0], 2562);
    end
    chk("held_write_count", wa.size() >= 1024, 1);
    #2 reset = 1'b0;
    @(negedge clk) reset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
